// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory-stage controller.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP,
      ERR
   } state_t;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_t;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_TIMEOUT = 63;
   localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/mem_stage_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: holds one load/store toward a multi-cycle memory,
// stalls the pipeline meanwhile, and reports errors and hit/miss statistics.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int ALIGN_CHECK = 1,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              createdump,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              mem_createdump,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   input  logic              mem_hit,
   input  logic              mem_err,
   output logic [DATA_W-1:0] rd_data,
   output logic              resp_valid,
   output logic              cache_hit,
   output logic              pipe_stall,
   output logic              err,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] TIMEOUT_V = WD_W'(TIMEOUT);

   state_t          state;
   op_t             op;
   logic [WD_W-1:0] wdog;
   logic            req_any;
   logic            req_bad;
   logic            timeout_hit;
   logic            hit_inc;
   logic            miss_inc;

   assign req_any     = req_rd | req_wr;
   assign req_bad     = (req_rd & req_wr) | ((ALIGN_CHECK != 0) && req_addr[0]);
   // wdog holds the number of BUSY cycles already completed, so this fires on the TIMEOUT-th one
   assign timeout_hit = ((wdog + WD_W'(1)) == TIMEOUT_V);
   assign hit_inc     = (state == BUSY) & mem_done & mem_hit;
   assign miss_inc    = (state == BUSY) & mem_done & ~mem_hit;

   assign pipe_stall     = ~rst & (((state == IDLE) & req_any) | (state == BUSY));
   assign mem_createdump = createdump;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op         <= OP_RD;
         wdog       <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         rd_data    <= '0;
         resp_valid <= 1'b0;
         cache_hit  <= 1'b0;
         err        <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  if (req_bad) begin
                     state      <= ERR;
                     err        <= 1'b1;
                     resp_valid <= 1'b1;
                     rd_data    <= '0;
                  end else begin
                     state     <= BUSY;
                     op        <= req_wr ? OP_WR : OP_RD;
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata;
                     mem_rd    <= req_rd;
                     mem_wr    <= req_wr;
                     wdog      <= '0;
                  end
               end
            end
            BUSY: begin
               wdog <= wdog + WD_W'(1);
               // a memory error outranks a simultaneous completion
               if (mem_err || (timeout_hit && !mem_done)) begin
                  state      <= ERR;
                  mem_rd     <= 1'b0;
                  mem_wr     <= 1'b0;
                  err        <= 1'b1;
                  resp_valid <= 1'b1;
                  rd_data    <= '0;
               end else if (mem_done) begin
                  state      <= RESP;
                  mem_rd     <= 1'b0;
                  mem_wr     <= 1'b0;
                  resp_valid <= 1'b1;
                  cache_hit  <= mem_hit;
                  if (op == OP_RD) begin
                     rd_data <= mem_rdata;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_hit_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.W(CNT_W)) u_miss_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_mem_stage_ctrl;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int NEVER   = 1000;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_rd;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              createdump;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic              mem_createdump;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              mem_hit;
   logic              mem_err;
   logic [DATA_W-1:0] rd_data;
   logic              resp_valid;
   logic              cache_hit;
   logic              pipe_stall;
   logic              err;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] expRdata;
   int                expHits;
   int                expMisses;
   bit                expErr;

   always #5 clk = ~clk;

   mem_stage_ctrl #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .ALIGN_CHECK (1),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_rd         (req_rd),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .createdump     (createdump),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .mem_createdump (mem_createdump),
      .mem_rdata      (mem_rdata),
      .mem_done       (mem_done),
      .mem_hit        (mem_hit),
      .mem_err        (mem_err),
      .rd_data        (rd_data),
      .resp_valid     (resp_valid),
      .cache_hit      (cache_hit),
      .pipe_stall     (pipe_stall),
      .err            (err),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   function automatic int minOf(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Every comparison in the bench goes through here
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_hits"}, 32'(hit_count), 32'(expHits));
      checkOutput({tag, "_misses"}, 32'(miss_count), 32'(expMisses));
   endtask

   task automatic dropRequest();
      req_rd    = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   // Reset pulse, then confirm every registered output has cleared
   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1;
      mem_done = 1'b0;
      mem_err  = 1'b0;
      mem_hit  = 1'b0;
      #1;
      checkOutput("rst_stall_forced", 32'(pipe_stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dropRequest();
      expRdata  = '0;
      expHits   = 0;
      expMisses = 0;
      expErr    = 1'b0;
      #1;
      checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
      checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
      checkOutput("rst_cache_hit", 32'(cache_hit), 32'd0);
      checkCounters("rst");
   endtask

   task automatic idleCycle();
      @(negedge clk);
      dropRequest();
      createdump = 1'($urandom_range(0, 1));
      #1;
      checkOutput("idle_stall", 32'(pipe_stall), 32'd0);
      checkOutput("idle_mem_rd", 32'(mem_rd), 32'd0);
      checkOutput("idle_mem_wr", 32'(mem_wr), 32'd0);
      checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("idle_err", 32'(err), 32'(expErr));
      checkOutput("idle_createdump", 32'(mem_createdump), 32'(createdump));
   endtask

   // One pipeline request plus the memory's reaction: completion at BUSY cycle
   // 'lat', memory error at BUSY cycle 'errAt' (NEVER for none).
   task automatic applyStimulus(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int lat, input int errAt,
                                input bit hit, input logic [DATA_W-1:0] rdata);
      int  lastCycle;
      bit  errOut;
      @(negedge clk);
      req_rd    = rd;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      mem_done  = 1'b0;
      mem_err   = 1'b0;
      #1;
      if (expErr) begin
         checkOutput("ignored_stall", 32'(pipe_stall), 32'd0);
         checkOutput("ignored_err", 32'(err), 32'd1);
         @(negedge clk);
         #1;
         checkOutput("ignored_mem_rd", 32'(mem_rd), 32'd0);
         checkOutput("ignored_mem_wr", 32'(mem_wr), 32'd0);
         checkOutput("ignored_resp", 32'(resp_valid), 32'd0);
         return;
      end
      if (!rd && !wr) begin
         checkOutput("norq_stall", 32'(pipe_stall), 32'd0);
         return;
      end
      checkOutput("req_stall", 32'(pipe_stall), 32'd1);
      checkOutput("req_no_strobe", 32'({mem_rd, mem_wr}), 32'd0);
      if ((rd && wr) || addr[0]) begin
         @(negedge clk);
         #1;
         checkOutput("bad_err", 32'(err), 32'd1);
         checkOutput("bad_resp", 32'(resp_valid), 32'd1);
         checkOutput("bad_rd_data", 32'(rd_data), 32'd0);
         checkOutput("bad_stall", 32'(pipe_stall), 32'd0);
         checkOutput("bad_no_strobe", 32'({mem_rd, mem_wr}), 32'd0);
         expErr   = 1'b1;
         expRdata = '0;
         return;
      end
      lastCycle = minOf(minOf(lat, errAt), TIMEOUT);
      for (int k = 1; k <= lastCycle; k++) begin
         @(negedge clk);
         mem_done  = (k == lat);
         mem_err   = (k == errAt);
         mem_hit   = hit;
         mem_rdata = (k == lat) ? rdata : DATA_W'($urandom);
         #1;
         checkOutput("busy_mem_rd", 32'(mem_rd), 32'(rd));
         checkOutput("busy_mem_wr", 32'(mem_wr), 32'(wr));
         checkOutput("busy_addr", 32'(mem_addr), 32'(addr));
         checkOutput("busy_wdata", 32'(mem_wdata), 32'(wdata));
         checkOutput("busy_stall", 32'(pipe_stall), 32'd1);
         checkOutput("busy_resp", 32'(resp_valid), 32'd0);
      end
      errOut = (errAt == lastCycle) || (lat != lastCycle);
      if (lat == lastCycle) begin
         if (hit) expHits = minOf(expHits + 1, CNT_MAX);
         else     expMisses = minOf(expMisses + 1, CNT_MAX);
      end
      @(negedge clk);
      mem_done = 1'b0;
      mem_err  = 1'b0;
      mem_hit  = 1'b0;
      #1;
      checkOutput("resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("resp_stall", 32'(pipe_stall), 32'd0);
      checkOutput("resp_no_strobe", 32'({mem_rd, mem_wr}), 32'd0);
      checkCounters("resp");
      if (errOut) begin
         expErr   = 1'b1;
         expRdata = '0;
         checkOutput("resp_err", 32'(err), 32'd1);
      end else begin
         if (rd) expRdata = rdata;
         checkOutput("resp_err", 32'(err), 32'd0);
         checkOutput("resp_cache_hit", 32'(cache_hit), 32'(hit));
      end
      checkOutput("resp_rd_data", 32'(rd_data), 32'(expRdata));
   endtask

   task automatic resetMidBusy();
      @(negedge clk);
      req_rd   = 1'b1;
      req_wr   = 1'b0;
      req_addr = 16'h0040;
      mem_done = 1'b0;
      mem_err  = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #1;
         checkOutput("midrst_busy_rd", 32'(mem_rd), 32'd1);
      end
      resetDut();
      @(negedge clk);
      #1;
      checkOutput("midrst_no_resp", 32'(resp_valid), 32'd0);
      checkOutput("midrst_mem_rd", 32'(mem_rd), 32'd0);
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      bit                rd;
      bit                wr;
      int                errAt;
      rst        = 1'b1;
      createdump = 1'b0;
      mem_rdata  = '0;
      mem_done   = 1'b0;
      mem_hit    = 1'b0;
      mem_err    = 1'b0;
      dropRequest();
      repeat (2) @(negedge clk);
      resetDut();
      idleCycle();

      applyStimulus(1, 0, 16'h0010, 16'h0000, 1, NEVER, 1, 16'hBEEF);
      idleCycle();
      applyStimulus(0, 1, 16'h0020, 16'h1234, 4, NEVER, 0, 16'h0000);
      idleCycle();
      applyStimulus(1, 0, 16'h0030, 16'h0000, 2, NEVER, 1, 16'h1111);
      applyStimulus(1, 0, 16'h0030, 16'h0000, 1, NEVER, 1, 16'h2222);
      idleCycle();
      applyStimulus(1, 0, 16'h0032, 16'h0000, 1, NEVER, 1, 16'h3333);
      applyStimulus(1, 0, 16'h0034, 16'h0000, 3, NEVER, 1, 16'h4444);
      idleCycle();
      applyStimulus(1, 0, 16'h0050, 16'h0000, NEVER, NEVER, 0, 16'h0000);
      applyStimulus(1, 0, 16'h0052, 16'h0000, 1, NEVER, 1, 16'h5555);
      idleCycle();

      resetDut();
      applyStimulus(1, 0, 16'h0013, 16'h0000, 1, NEVER, 1, 16'h6666);
      applyStimulus(0, 1, 16'h0014, 16'h7777, 1, NEVER, 1, 16'h0000);
      resetDut();
      applyStimulus(1, 1, 16'h0016, 16'h7777, 1, NEVER, 1, 16'h0000);
      resetDut();
      resetMidBusy();
      applyStimulus(1, 0, 16'h0060, 16'h0000, 2, 2, 1, 16'hAAAA);
      resetDut();

      for (int n = 0; n < 300; n++) begin
         if (expErr && ($urandom_range(0, 1) == 0)) resetDut();
         if ($urandom_range(0, 3) == 0) idleCycle();
         a = ADDR_W'($urandom);
         if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
         rd = 1'($urandom_range(0, 1));
         wr = ~rd;
         if ($urandom_range(0, 15) == 0) begin
            rd = 1'b1;
            wr = 1'b1;
         end
         errAt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 10)) : NEVER;
         applyStimulus(rd, wr, a, DATA_W'($urandom), int'($urandom_range(1, 10)), errAt,
                       1'($urandom_range(0, 1)), DATA_W'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised memory-stage controller between the EX/MEM pipeline register and a multi-cycle data memory system (Addr/DataIn/Rd/Wr/Done/Stall/CacheHit/err interface).
- Latches each load/store and holds a stable request to memory until completion.
- Stalls the pipeline while the access is outstanding and returns a registered response.
- Adds behaviour the plain wrapper lacks: misalignment and illegal-op detection, a timeout watchdog, a sticky error, and saturating hit/miss counters.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, byte address width.
- ALIGN_CHECK, 1, when 1, flag an error if addr[0]=1 (word accesses only).
- TIMEOUT, 63, max BUSY cycles before watchdog error; must be >=1.
- CNT_W, 16, width of hit/miss counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_rd  in  1  load request from pipeline.
- req_wr  in  1  store request from pipeline.
- req_addr  in  ADDR_W  access address (ALU result).
- req_wdata  in  DATA_W  store data.
- createdump  in  1  forwarded combinationally to mem_createdump.
- mem_addr  out  ADDR_W  latched address to memory.
- mem_wdata  out  DATA_W  latched store data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_createdump  out  1  dump request.
- mem_rdata  in  DATA_W  memory read data.
- mem_done  in  1  access complete this cycle.
- mem_hit  in  1  valid with mem_done.
- mem_err  in  1  memory-reported error.
- rd_data  out  DATA_W  registered load result.
- resp_valid  out  1  one-cycle response pulse.
- cache_hit  out  1  registered hit flag of last access.
- pipe_stall  out  1  freeze upstream stages.
- err  out  1  sticky error.
- hit_count  out  CNT_W  saturating hit count.
- miss_count  out  CNT_W  saturating miss count.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: state IDLE; all registered outputs 0. pipe_stall is forced 0 while rst=1.
- States: IDLE, BUSY, RESP, ERR.
- IDLE, no request: mem_rd = mem_wr = 0, pipe_stall = 0.
- IDLE, request present (req_rd|req_wr):
  - pipe_stall = 1 combinationally.
  - If req_rd & req_wr, or (ALIGN_CHECK and req_addr[0]): go to ERR; no memory access issued.
  - Otherwise: latch addr/wdata/op, clear the watchdog, go to BUSY.
- BUSY:
  - mem_rd/mem_wr driven from the latched op; mem_addr/mem_wdata are stable; pipe_stall = 1.
  - On mem_done: rd_data <= mem_rdata (loads only; stores leave rd_data unchanged), cache_hit <= mem_hit, increment hit_count or miss_count, go to RESP.
  - On mem_err, or watchdog reaching TIMEOUT without mem_done: go to ERR.
  - mem_err and mem_done in the same cycle: ERR wins; counters still update.
- RESP: resp_valid = 1, pipe_stall = 0, mem strobes 0, request inputs ignored (the pipeline still shows the old request this cycle); go to IDLE next.
- Minimum latency: request in cycle 0, mem_done in cycle 1, resp_valid in cycle 2; pipe_stall high in cycles 0–1.
- ERR (terminal until rst):
  - err = 1, pipe_stall = 0, mem strobes 0.
  - One resp_valid pulse on entry with rd_data = 0; requests ignored thereafter.
- Counters saturate at all-ones and never wrap.
- Reset mid-BUSY: the strobes drop on the cycle after rst is sampled; no response is produced; counters clear.
- Watchdog: CNT width = clog2(TIMEOUT+1). It counts BUSY cycles and is compared for equality with TIMEOUT.

Decomposition:
- Package mem_stage_pkg:
  - state enum (IDLE, BUSY, RESP, ERR);
  - op encoding (OP_RD, OP_WR);
  - default width constants.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated for hit_count and miss_count.

Test Plan:
- Load hit: req_rd, addr 0x0010, mem_done + mem_hit in the first BUSY cycle with mem_rdata 0xBEEF -> pipe_stall high for 2 cycles; resp_valid in cycle 2; rd_data 0xBEEF; cache_hit 1; hit_count 1.
- Store miss: req_wr, addr 0x0020, wdata 0x1234, mem_done after 4 BUSY cycles with mem_hit 0 -> mem_wr held 4 cycles with stable addr/data; miss_count 1; rd_data unchanged.
- Misaligned: req_rd, addr 0x0013 -> mem_rd never asserted; err 1 the next cycle; resp_valid pulse with rd_data 0; later requests ignored.
- Timeout with TIMEOUT=8: req_rd, mem_done held 0 -> err rises exactly 8 BUSY cycles after entry; mem_rd drops.
- Back-to-back: two loads with the request held through stall -> exactly two memory accesses and two resp_valid pulses; the RESP cycle does not re-issue.
- Saturation and reset: CNT_W=2 with 5 hits -> hit_count 3; rst asserted mid-BUSY -> IDLE, strobes 0, counters 0, no resp_valid.
